// File: rtl/wor_arb_pkg.sv
// Shared types and constants for the wired-OR bus arbiter.
package wor_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   localparam int unsigned HOLD_CNT_W  = 8;
   localparam int unsigned TURN_CYCLES = 1;

endpackage

// File: rtl/wor_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr, wrapping.
module rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [N_REQ-1:0] win_oh,
   output logic [PTR_W-1:0] win_idx,
   output logic             valid
);

   logic [PTR_W-1:0] idx;

   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      valid   = 1'b0;
      idx     = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = PTR_W'((32'(rr_ptr) + k) % N_REQ);
         if (!valid && req[idx]) begin
            valid       = 1'b1;
            win_oh[idx] = 1'b1;
            win_idx     = idx;
         end
      end
   end

endmodule

// File: rtl/wor_bus_arbiter.sv
// Round-robin arbiter for a shared wired-OR bus with turnaround and hold limit.
// Optional stray-data detector enabled by defining WOR_ARB_STRAY_CHK_EN.
module wor_bus_arbiter
   import wor_arb_pkg::*;
#(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned MAX_HOLD = 15
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ-1:0]        done,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        grant,
   output logic [DATA_W-1:0]       bus_out,
   output logic                    busy,
`ifdef WOR_ARB_STRAY_CHK_EN
   output logic                    stray_err,
`endif
   output logic                    timeout_err
);

   localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t                state;
   logic [PTR_W-1:0]      rr_ptr;
   logic [PTR_W-1:0]      win_idx;
   logic [PTR_W-1:0]      rr_ptr_nxt;
   logic [N_REQ-1:0]      win_oh;
   logic                  win_vld;
   logic [HOLD_CNT_W-1:0] hold_cnt;
   logic                  own_done;
   logic                  own_req;
   logic                  hold_hit;

   rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
      .req     (req),
      .rr_ptr  (rr_ptr),
      .win_oh  (win_oh),
      .win_idx (win_idx),
      .valid   (win_vld)
   );

   assign own_done   = |(done & grant);
   assign own_req    = |(req & grant);
   assign hold_hit   = (hold_cnt == HOLD_CNT_W'(MAX_HOLD));
   assign rr_ptr_nxt = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

   // IDLE and TURN arbitrate identically; TURN is the forced grant-free cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         grant       <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         rr_ptr      <= '0;
         hold_cnt    <= '0;
      end else begin
         timeout_err <= 1'b0;
         unique case (state)
            IDLE, TURN: begin
               if (win_vld) begin
                  state    <= GRANT;
                  grant    <= win_oh;
                  busy     <= 1'b1;
                  hold_cnt <= HOLD_CNT_W'(1);
                  rr_ptr   <= rr_ptr_nxt;
               end else begin
                  state    <= IDLE;
                  grant    <= '0;
                  busy     <= 1'b0;
                  hold_cnt <= '0;
               end
            end
            GRANT: begin
               if (own_done || !own_req || hold_hit) begin
                  state       <= TURN;
                  grant       <= '0;
                  busy        <= 1'b0;
                  hold_cnt    <= '0;
                  timeout_err <= hold_hit && !own_done && own_req;
               end else begin
                  hold_cnt <= hold_cnt + HOLD_CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               grant <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Masked OR of all lanes; grant is at most one-hot.
   always_comb begin
      bus_out = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         bus_out = bus_out | (req_data[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}});
      end
   end

`ifdef WOR_ARB_STRAY_CHK_EN
   logic stray_c;

   always_comb begin
      stray_c = 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (!grant[i] && (req_data[i*DATA_W +: DATA_W] != '0)) stray_c = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stray_err <= 1'b0;
      else        stray_err <= stray_c;
   end
`endif

endmodule

// File: tb/tb_wor_bus_arbiter.sv
// Scoreboard bench for wor_bus_arbiter against a cycle-level behavioural model.
module tb_wor_bus_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MH = 15;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     req;
   logic [N-1:0]     done;
   logic [N*W-1:0]   req_data;
   logic [N-1:0]     grant;
   logic [W-1:0]     bus_out;
   logic             busy;
   logic             timeout_err;
`ifdef WOR_ARB_STRAY_CHK_EN
   logic             stray_err;
`endif

   typedef struct {
      logic [N-1:0] grant;
      logic [W-1:0] bus;
      logic         busy;
      logic         tout;
      logic         stray;
   } exp_t;

   exp_t q[$];
   int   compared   = 0;
   int   mismatched = 0;

   // model state: current owner (-1 none), cycles held, next search start
   int owner = -1;
   int held  = 0;
   int ptr   = 0;

   wor_bus_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_HOLD(MH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .done        (done),
      .req_data    (req_data),
      .grant       (grant),
      .bus_out     (bus_out),
      .busy        (busy),
`ifdef WOR_ARB_STRAY_CHK_EN
      .stray_err   (stray_err),
`endif
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] lane(input int i);
      return req_data[i*W +: W];
   endfunction

   // Advance the model across the coming edge using the inputs now driven.
   task automatic step();
      exp_t e;
      logic tout;
      logic stray;
      int   i;
      tout  = 1'b0;
      stray = 1'b0;
      for (int j = 0; j < N; j++) if (j != owner && lane(j) != '0) stray = 1'b1;
      if (owner >= 0) begin
         if (done[owner] || !req[owner] || held == MH) begin
            tout  = (held == MH) && !done[owner] && req[owner];
            owner = -1;
            held  = 0;
         end else begin
            held++;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            i = (ptr + k) % N;
            if (req[i]) begin
               owner = i;
               held  = 1;
               ptr   = (i + 1) % N;
               break;
            end
         end
      end
      e.grant = (owner >= 0) ? (N'(1) << owner) : '0;
      e.bus   = (owner >= 0) ? lane(owner) : '0;
      e.busy  = (owner >= 0);
      e.tout  = tout;
      e.stray = stray;
      q.push_back(e);
   endtask

   task automatic drive(input logic [N-1:0] r, input logic [N-1:0] d, input logic [N*W-1:0] dat);
      req      = r;
      done     = d;
      req_data = dat;
      step();
   endtask

   function automatic logic [N-1:0] own_done_at(input int h);
      return (owner >= 0 && held == h) ? (N'(1) << owner) : '0;
   endfunction

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("grant",       32'(grant),       32'(e.grant));
         check("bus_out",     32'(bus_out),     32'(e.bus));
         check("busy",        32'(busy),        32'(e.busy));
         check("timeout_err", 32'(timeout_err), 32'(e.tout));
`ifdef WOR_ARB_STRAY_CHK_EN
         check("stray_err",   32'(stray_err),   32'(e.stray));
`endif
      end
   end

   initial begin
      logic [N*W-1:0] dat;
      logic [N-1:0]   r;
      rst_n    = 1'b0;
      req      = '1;
      done     = '0;
      req_data = '0;
      repeat (2) @(negedge clk);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_bus",   32'(bus_out), 32'd0);
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_tout",  32'(timeout_err), 32'd0);

      @(negedge clk);
      rst_n = 1'b1;
      drive('1, '0, '0);

      // round-robin, owner releases after two cycles; lane 2 carries A5
      repeat (16) begin
         @(negedge clk);
         dat = '0;
         if (owner >= 0) dat[owner*W +: W] = (owner == 2) ? 8'hA5 : W'($urandom_range(1, 255));
         drive('1, own_done_at(2), dat);
      end

      // timeout on a lone requester, then re-grant
      repeat (40) begin
         @(negedge clk);
         drive(4'b0100, '0, 32'h003C_0000);
      end

      // done coinciding with the hold limit is a normal release
      repeat (20) begin
         @(negedge clk);
         drive(4'b0100, own_done_at(MH), 32'h005A_0000);
      end

      // wrap from pointer 3 back to 0
      repeat (8) begin
         @(negedge clk);
         drive(4'b1001, own_done_at(2), 32'h7700_0011);
      end
      for (int n = 0; n < 4 && owner < 0; n++) begin
         @(negedge clk);
         drive(4'b1001, '0, 32'h7700_0011);
      end
      @(posedge clk);
      #3;
      check("pre_rst_busy", 32'(busy), 32'(owner >= 0));
      rst_n = 1'b0;
      #1;
      check("mid_rst_grant", 32'(grant), 32'd0);
      check("mid_rst_bus",   32'(bus_out), 32'd0);
      check("mid_rst_busy",  32'(busy), 32'd0);
      owner = -1;
      held  = 0;
      ptr   = 0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b1010, '0, 32'h0000_4400);

      // randomized traffic with slowly changing requests
      r = N'($urandom);
      repeat (400) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) r = N'($urandom);
         drive(r, N'($urandom & $urandom & $urandom), $urandom);
      end

      // stray data on a non-granted lane, then clean
      repeat (4) begin
         @(negedge clk);
         drive(4'b0001, '0, 32'h0000_0100);
      end
      repeat (4) begin
         @(negedge clk);
         drive(4'b0001, '0, 32'h0000_0033);
      end
      repeat (4) begin
         @(negedge clk);
         drive('0, '0, '0);
      end
      repeat (3) @(negedge clk);
      check("drain", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
